vector_store_unit: RTL and testbench

Writes one 512-bit vector register back to the 32-bit word memory as 16 consecutive word writes. It is the store path of the vector processor: it captures a register-file read value and a base address, then serialises them onto the memory write port. It complements the existing word-in path, which builds vectors from 32-bit data.

---
 rtl/vec_pkg.sv | 23 ++
 rtl/vector_store_unit.sv | 110 +++++++++++
 tb/tb_vector_store_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit types and constants, used by the vector store path
// (and by the future vector load unit).
package vec_pkg;

   localparam int unsigned VLEN   = 512;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned NWORDS = VLEN / WORD_W;
   localparam int unsigned CNT_W  = $clog2(NWORDS);

   typedef logic [VLEN-1:0]   vec_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [NWORDS-1:0] mask_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STORE,
      ST_DONE
   } st_state_e;

endpackage : vec_pkg

// File: rtl/vector_store_unit.sv
// Serialises one captured 512-bit vector into 16 consecutive 32-bit memory writes.
// Optional per-word write mask enabled by defining VSTORE_MASK_EN.
module vector_store_unit
   import vec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [VLEN-1:0]   src_vec,
   input  logic [ADDR_W-1:0] base_addr,
`ifdef VSTORE_MASK_EN
   input  logic [NWORDS-1:0] word_mask,
`endif
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data,
   output logic              mem_we,
   output logic              busy,
   output logic              done
);

   st_state_e state_q, state_d;
   vec_t      cap_q,   cap_d;
   addr_t     addr_q,  addr_d;
   cnt_t      cnt_q,   cnt_d;
   mask_t     mask_q,  mask_d;
   logic      mem_we_q, mem_we_d;
   logic      busy_q,   busy_d;
   logic      done_q,   done_d;
   logic      advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cap_q    <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         mem_we_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cap_q    <= cap_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         mem_we_q <= mem_we_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // A masked slot never waits for the memory; it just burns its cycle.
   assign advance = mem_ready || !mask_q[0];

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STORE;
               cap_d   = src_vec;
               addr_d  = base_addr;
               cnt_d   = '0;
`ifdef VSTORE_MASK_EN
               mask_d  = word_mask;
`else
               mask_d  = '1;
`endif
            end
         end
         ST_STORE: begin
            // Last word keeps address/data so the bus holds its final value.
            if (advance) begin
               if (cnt_q == CNT_W'(NWORDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  cap_d  = cap_q >> WORD_W;
                  addr_d = addr_q + ADDR_W'(1);
                  cnt_d  = cnt_q + CNT_W'(1);
                  mask_d = mask_q >> 1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      mem_we_d = (state_d == ST_STORE) && mask_d[0];
      busy_d   = (state_d == ST_STORE);
      done_d   = (state_d == ST_DONE);
   end

   assign mem_addr = addr_q;
   assign mem_data = cap_q[WORD_W-1:0];
   assign mem_we   = mem_we_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule : vector_store_unit

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench for vector_store_unit: expected writes are queued at issue
// time and a negedge monitor pops/compares every accepted memory write.
module tb_vector_store_unit;
   import vec_pkg::*;

   localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [VLEN-1:0]   src_vec;
   logic [ADDR_W-1:0] base_addr;
   logic [NWORDS-1:0] word_mask;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_data;
   logic              mem_we;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_err    = 0;

   logic [40:0] exp_q[$];
   logic [31:0] mem [512];

   vector_store_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_vec   (src_vec),
      .base_addr (base_addr),
`ifdef VSTORE_MASK_EN
      .word_mask (word_mask),
`endif
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] make_vec(input logic [31:0] b);
      logic [VLEN-1:0] v;
      for (int k = 0; k < int'(NWORDS); k++) v[k*32 +: 32] = b + 32'(k);
      return v;
   endfunction

   // Monitor: a write is accepted at the next posedge when we and ready are both high.
   always @(negedge clk) begin
      if (!rst && mem_we && mem_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {23'd0, mem_addr, mem_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [40:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e[40:32]));
            check("wr_data", 64'(mem_data), 64'(e[31:0]));
         end
         mem[mem_addr] = mem_data;
      end
   end

   // Called at posedge+1 while idle; returns after start has been sampled.
   task automatic issue(input logic [31:0] vb, input logic [ADDR_W-1:0] b, input logic [15:0] m);
      logic [ADDR_W-1:0] a;
      for (int k = 0; k < int'(NWORDS); k++) begin
         a = b + ADDR_W'(k);
         if (m[k]) exp_q.push_back({a, vb + 32'(k)});
      end
      src_vec   = make_vec(vb);
      base_addr = b;
      word_mask = m;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic run_store(input int stall_at, input int stall_len,
                            input logic [ADDR_W-1:0] h_addr, input logic [31:0] h_data,
                            input int ign_at, input int rst_at,
                            output int busy_cnt, output int done_at);
      busy_cnt = 0;
      done_at  = -1;
      for (int c = 0; c < 60; c++) begin
         mem_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (c == ign_at) begin
            start     = 1'b1;
            src_vec   = make_vec(32'hBAD0_0000);
            base_addr = 9'h055;
         end
         if (c == ign_at + 1) start = 1'b0;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_mid_addr", 64'(mem_addr), 64'd0);
            check("rst_mid_data", 64'(mem_data), 64'd0);
            check("rst_mid_we",   64'(mem_we),   64'd0);
            check("rst_mid_busy", 64'(busy),     64'd0);
            check("rst_mid_done", 64'(done),     64'd0);
            exp_q.delete();
            mem_ready = 1'b1;
            return;
         end
         @(negedge clk);
         if (busy) busy_cnt++;
         if (!mem_ready && busy) begin
            check("stall_we",   64'(mem_we),   64'd1);
            check("stall_addr", 64'(mem_addr), 64'(h_addr));
            check("stall_data", 64'(mem_data), 64'(h_data));
         end
         if (done) begin
            done_at = c;
            check("done_we_low", 64'(mem_we), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_after_done", 64'(busy), 64'd0);
            mem_ready = 1'b1;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      check("done_timeout", 64'(done_at), 64'd16);
   endtask

   int bc, da;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = SENTINEL;
      rst = 1'b1; start = 1'b0; src_vec = '0; base_addr = '0;
      word_mask = '1; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_addr", 64'(mem_addr), 64'd0);
      check("reset_data", 64'(mem_data), 64'd0);
      check("reset_we",   64'(mem_we),   64'd0);
      check("reset_busy", 64'(busy),     64'd0);
      check("reset_done", 64'(done),     64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic store
      issue(32'hA000_0000, 9'h010, 16'hFFFF);
      run_store(-100, 0, '0, '0, -100, -1, bc, da);
      check("basic_busy_cycles", 64'(bc), 64'd16);
      check("basic_done_cycle",  64'(da), 64'd16);
      check("basic_mem_first",   64'(mem[9'h010]), 64'hA000_0000);
      check("basic_mem_last",    64'(mem[9'h01F]), 64'hA000_000F);

      // Address wrap-around
      issue(32'hB000_0000, 9'h1F8, 16'hFFFF);
      run_store(-100, 0, '0, '0, -100, -1, bc, da);
      check("wrap_done_cycle", 64'(da), 64'd16);
      check("wrap_mem_1ff", 64'(mem[9'h1FF]), 64'hB000_0007);
      check("wrap_mem_000", 64'(mem[9'h000]), 64'hB000_0008);
      check("wrap_mem_007", 64'(mem[9'h007]), 64'hB000_000F);

      // Backpressure on word 5
      issue(32'hC100_0000, 9'h040, 16'hFFFF);
      run_store(5, 3, 9'h045, 32'hC100_0005, -100, -1, bc, da);
      check("bp_busy_cycles", 64'(bc), 64'd19);
      check("bp_done_cycle",  64'(da), 64'd19);

      // Start pulsed mid-store is ignored
      issue(32'hC000_0000, 9'h080, 16'hFFFF);
      run_store(-100, 0, '0, '0, 8, -1, bc, da);
      check("ign_done_cycle", 64'(da), 64'd16);
      check("ign_mem_word8",  64'(mem[9'h088]), 64'hC000_0008);
      check("ign_mem_other",  64'(mem[9'h055]), 64'(SENTINEL));
      repeat (3) @(negedge clk);
      check("ign_no_second_store", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Reset after 6 accepted words, then a full store
      issue(32'hD000_0000, 9'h100, 16'hFFFF);
      run_store(-100, 0, '0, '0, -100, 6, bc, da);
      check("rst_mem_word5", 64'(mem[9'h105]), 64'hD000_0005);
      check("rst_mem_word6", 64'(mem[9'h106]), 64'(SENTINEL));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(32'hE000_0000, 9'h100, 16'hFFFF);
      run_store(-100, 0, '0, '0, -100, -1, bc, da);
      check("rst_full_busy", 64'(bc), 64'd16);
      check("rst_full_last", 64'(mem[9'h10F]), 64'hE000_000F);

`ifdef VSTORE_MASK_EN
      // Odd words only; even slots skipped without touching memory
      issue(32'hF000_0000, 9'h180, 16'hAAAA);
      run_store(-100, 0, '0, '0, -100, -1, bc, da);
      check("mask_done_cycle", 64'(da), 64'd16);
      check("mask_even_untouched", 64'(mem[9'h184]), 64'(SENTINEL));
      check("mask_odd_written",    64'(mem[9'h185]), 64'hF000_0005);
`endif

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_vector_store_unit
